// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if
//   Bundles the controller-to-datapath signals of the multicycle MIPS core.
//   Parameters: OP_W (opcode/funct width), CNT_W (retired-instruction counter width).
//   master : controller side (samples Opcode/Funct/Zero_Flag, drives controls)
//   slave  : datapath side  (drives Opcode/Funct/Zero_Flag, samples controls)
//   Signals: Opcode, Funct, Zero_Flag, ALU_Control, ALU_SrcA, ALU_SrcB, IorD,
//            Mem_Write, IR_Write, Reg_Write, Reg_Dst, Mem_to_Reg, PC_Src,
//            PC_En, Illegal_Op, Instr_Count.
interface mips_multicycle_ctrl_if #(
    parameter int unsigned OP_W  = 6,
    parameter int unsigned CNT_W = 32
);
    logic [OP_W-1:0]  Opcode;
    logic [OP_W-1:0]  Funct;
    logic             Zero_Flag;
    logic [2:0]       ALU_Control;
    logic             ALU_SrcA;
    logic [1:0]       ALU_SrcB;
    logic             IorD;
    logic             Mem_Write;
    logic             IR_Write;
    logic             Reg_Write;
    logic             Reg_Dst;
    logic             Mem_to_Reg;
    logic [1:0]       PC_Src;
    logic             PC_En;
    logic             Illegal_Op;
    logic [CNT_W-1:0] Instr_Count;

    modport master (
        input  Opcode, Funct, Zero_Flag,
        output ALU_Control, ALU_SrcA, ALU_SrcB, IorD, Mem_Write, IR_Write,
               Reg_Write, Reg_Dst, Mem_to_Reg, PC_Src, PC_En, Illegal_Op,
               Instr_Count
    );

    modport slave (
        output Opcode, Funct, Zero_Flag,
        input  ALU_Control, ALU_SrcA, ALU_SrcB, IorD, Mem_Write, IR_Write,
               Reg_Write, Reg_Dst, Mem_to_Reg, PC_Src, PC_En, Illegal_Op,
               Instr_Count
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Multicycle MIPS main control FSM. Decodes Opcode/Funct and sequences the
//   datapath enables and ALU_Control each cycle; resolves beq with Zero_Flag.
//   Ports: CLK (rising edge), RST (async, active-high),
//          bus (mips_multicycle_ctrl_if.master: decode inputs, control outputs,
//          retired-instruction counter).
//   Optional feature: define ALU_MUL_EN to decode R-type funct 011000 as MUL.
//   Control outputs are Moore decodes of the state register (plus the IR fields
//   in DECODE/EXEC); PC_En alone mixes in Zero_Flag in the same cycle.
module mips_multicycle_ctrl #(
    parameter int unsigned OP_W  = 6,
    parameter int unsigned CNT_W = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    mips_multicycle_ctrl_if.master bus
);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

    localparam logic [OP_W-1:0] FN_ADD = OP_W'(6'b100000);
    localparam logic [OP_W-1:0] FN_SUB = OP_W'(6'b100010);
    localparam logic [OP_W-1:0] FN_AND = OP_W'(6'b100100);
    localparam logic [OP_W-1:0] FN_OR  = OP_W'(6'b100101);
    localparam logic [OP_W-1:0] FN_SLT = OP_W'(6'b101010);
`ifdef ALU_MUL_EN
    localparam logic [OP_W-1:0] FN_MUL = OP_W'(6'b011000);
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [2:0] alu_ctl;
    logic       src_a;
    logic [1:0] src_b;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       illegal;

    // State and retired-instruction counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next state, counter update and Moore control decode.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        alu_ctl    = 3'b000;
        src_a      = 1'b0;
        src_b      = 2'b00;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = 2'b00;
        pc_write   = 1'b0;
        branch     = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                ir_write = 1'b1;
                src_b    = 2'b01;
                alu_ctl  = 3'b010;
                pc_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut.
                src_b   = 2'b11;
                alu_ctl = 3'b010;
                case (bus.Opcode)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_ADDIEX;
                    OP_J:          state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a   = 1'b1;
                src_b   = 2'b10;
                alu_ctl = 3'b010;
                state_d = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
                count_d    = count_q + CNT_W'(1);
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = S_FETCH;
                count_d   = count_q + CNT_W'(1);
            end
            S_EXEC: begin
                src_a   = 1'b1;
                state_d = S_ALUWB;
                case (bus.Funct)
                    FN_ADD: alu_ctl = 3'b010;
                    FN_SUB: alu_ctl = 3'b100;
                    FN_AND: alu_ctl = 3'b000;
                    FN_OR:  alu_ctl = 3'b001;
                    FN_SLT: alu_ctl = 3'b110;
`ifdef ALU_MUL_EN
                    FN_MUL: alu_ctl = 3'b101;
`endif
                    default: begin
                        // Unknown funct: null ALU op, abandon without writeback.
                        alu_ctl = 3'b011;
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
                count_d   = count_q + CNT_W'(1);
            end
            S_BRANCH: begin
                src_a   = 1'b1;
                alu_ctl = 3'b100;
                pc_src  = 2'b01;
                branch  = 1'b1;
                state_d = S_FETCH;
                count_d = count_q + CNT_W'(1);
            end
            S_ADDIEX: begin
                src_a   = 1'b1;
                src_b   = 2'b10;
                alu_ctl = 3'b010;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
                count_d   = count_q + CNT_W'(1);
            end
            S_JUMP: begin
                pc_src   = 2'b10;
                pc_write = 1'b1;
                state_d  = S_FETCH;
                count_d  = count_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.ALU_Control = alu_ctl;
    assign bus.ALU_SrcA    = src_a;
    assign bus.ALU_SrcB    = src_b;
    assign bus.IorD        = iord;
    assign bus.Mem_Write   = mem_write;
    assign bus.IR_Write    = ir_write;
    assign bus.Reg_Write   = reg_write;
    assign bus.Reg_Dst     = reg_dst;
    assign bus.Mem_to_Reg  = mem_to_reg;
    assign bus.PC_Src      = pc_src;
    assign bus.PC_En       = pc_write | (branch & bus.Zero_Flag);
    assign bus.Illegal_Op  = illegal;
    assign bus.Instr_Count = count_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
//   Directed, table-driven bench for mips_multicycle_ctrl: one vector per clock
//   cycle with hand-computed control outputs and counter value, followed by
//   hand-written sequences for mid-instruction reset and same-cycle Zero_Flag.
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic [2:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic       iord;
        logic       memw;
        logic       irw;
        logic       regw;
        logic       regdst;
        logic       m2r;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       ill;
    } outs_t;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zf;
        outs_t       exp;
        logic [31:0] cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.OP_W(6), .CNT_W(32)) bus ();

    mips_multicycle_ctrl #(.OP_W(6), .CNT_W(32)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.master)
    );

    int          checks = 0;
    int          errors = 0;
    vec_t        vq[$];
    logic [31:0] c = 32'd0;

    outs_t O_IDLE, O_FETCH, O_DECODE, O_DECODE_ILL, O_MEMADR, O_MEMRD, O_MEMWB,
           O_MEMWR, O_EXEC_ILL, O_ALUWB, O_ADDIEX, O_ADDIWB, O_JUMP;

    function automatic outs_t mk(input logic [2:0] alu, input logic srca,
                                 input logic [1:0] srcb, input logic iord,
                                 input logic memw, input logic irw,
                                 input logic regw, input logic regdst,
                                 input logic m2r, input logic [1:0] pcsrc,
                                 input logic pcen, input logic ill);
        outs_t o;
        o = {alu, srca, srcb, iord, memw, irw, regw, regdst, m2r, pcsrc, pcen, ill};
        return o;
    endfunction

    function automatic outs_t o_exec(input logic [2:0] alu);
        return mk(alu, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    endfunction

    function automatic outs_t o_branch(input logic z);
        return mk(3'b100, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, z, 1'b0);
    endfunction

    task automatic add(input logic r, input logic [5:0] op, input logic [5:0] fn,
                       input logic zf, input outs_t e, input logic [31:0] cnt);
        vec_t v;
        v.rst = r; v.op = op; v.fn = fn; v.zf = zf; v.exp = e; v.cnt = cnt;
        vq.push_back(v);
    endtask

    // R-type that completes: FETCH, DECODE, EXEC, ALUWB.
    task automatic add_r(input logic [5:0] fn, input logic [2:0] alu);
        add(1'b0, 6'b000000, fn, 1'b0, O_FETCH, c);
        add(1'b0, 6'b000000, fn, 1'b1, O_DECODE, c);
        add(1'b0, 6'b000000, fn, 1'b1, o_exec(alu), c);
        add(1'b0, 6'b000000, fn, 1'b1, O_ALUWB, c);
        c = c + 32'd1;
    endtask

    // R-type with unknown funct: FETCH, DECODE, EXEC(illegal), no count.
    task automatic add_rbad(input logic [5:0] fn);
        add(1'b0, 6'b000000, fn, 1'b0, O_FETCH, c);
        add(1'b0, 6'b000000, fn, 1'b0, O_DECODE, c);
        add(1'b0, 6'b000000, fn, 1'b1, O_EXEC_ILL, c);
    endtask

    task automatic chk_outs(input string nm, input int idx, input outs_t exp);
        outs_t act;
        act = {bus.ALU_Control, bus.ALU_SrcA, bus.ALU_SrcB, bus.IorD, bus.Mem_Write,
               bus.IR_Write, bus.Reg_Write, bus.Reg_Dst, bus.Mem_to_Reg, bus.PC_Src,
               bus.PC_En, bus.Illegal_Op};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] outputs: got %b required %b", nm, idx, act, exp);
        end
    endtask

    task automatic chk_cnt(input string nm, input int idx, input logic [31:0] exp);
        checks++;
        if (bus.Instr_Count !== exp) begin
            errors++;
            $display("FAIL %s[%0d] Instr_Count: got %0d required %0d", nm, idx,
                     bus.Instr_Count, exp);
        end
    endtask

    task automatic chk_strobes(input string nm, input int idx);
        checks++;
        if ($countones({bus.Mem_Write, bus.IR_Write, bus.Reg_Write}) > 1) begin
            errors++;
            $display("FAIL %s[%0d] write strobes: got MW/IRW/RW=%b required at most one",
                     nm, idx, {bus.Mem_Write, bus.IR_Write, bus.Reg_Write});
        end
    endtask

    initial begin
        bus.Opcode    = 6'b000000;
        bus.Funct     = 6'b000000;
        bus.Zero_Flag = 1'b0;

        O_IDLE       = '0;
        O_FETCH      = mk(3'b010, 1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        O_DECODE     = mk(3'b010, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        O_DECODE_ILL = mk(3'b010, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        O_MEMADR     = mk(3'b010, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        O_MEMRD      = mk(3'b000, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        O_MEMWB      = mk(3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        O_MEMWR      = mk(3'b000, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        O_EXEC_ILL   = mk(3'b011, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        O_ALUWB      = mk(3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        O_ADDIEX     = mk(3'b010, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        O_ADDIWB     = mk(3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        O_JUMP       = mk(3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0);

        // Reset held two cycles, then released: still IDLE until the next edge.
        add(1'b1, 6'b000000, 6'b000000, 1'b0, O_IDLE, 32'd0);
        add(1'b1, 6'b000000, 6'b000000, 1'b1, O_IDLE, 32'd0);
        add(1'b0, 6'b000000, 6'b000000, 1'b0, O_IDLE, 32'd0);

        // R-type arithmetic/logic.
        add_r(6'b100000, 3'b010);
        add_r(6'b100010, 3'b100);
        add_r(6'b100100, 3'b000);
        add_r(6'b100101, 3'b001);
        add_r(6'b101010, 3'b110);

        // lw: 5 cycles.
        add(1'b0, 6'b100011, 6'b000000, 1'b0, O_FETCH, c);
        add(1'b0, 6'b100011, 6'b000000, 1'b0, O_DECODE, c);
        add(1'b0, 6'b100011, 6'b000000, 1'b1, O_MEMADR, c);
        add(1'b0, 6'b100011, 6'b000000, 1'b1, O_MEMRD, c);
        add(1'b0, 6'b100011, 6'b000000, 1'b1, O_MEMWB, c);
        c = c + 32'd1;

        // sw: 4 cycles.
        add(1'b0, 6'b101011, 6'b000000, 1'b0, O_FETCH, c);
        add(1'b0, 6'b101011, 6'b000000, 1'b0, O_DECODE, c);
        add(1'b0, 6'b101011, 6'b000000, 1'b0, O_MEMADR, c);
        add(1'b0, 6'b101011, 6'b000000, 1'b1, O_MEMWR, c);
        c = c + 32'd1;

        // beq taken / not taken: 3 cycles each.
        add(1'b0, 6'b000100, 6'b000000, 1'b0, O_FETCH, c);
        add(1'b0, 6'b000100, 6'b000000, 1'b1, O_DECODE, c);
        add(1'b0, 6'b000100, 6'b000000, 1'b1, o_branch(1'b1), c);
        c = c + 32'd1;
        add(1'b0, 6'b000100, 6'b000000, 1'b0, O_FETCH, c);
        add(1'b0, 6'b000100, 6'b000000, 1'b0, O_DECODE, c);
        add(1'b0, 6'b000100, 6'b000000, 1'b0, o_branch(1'b0), c);
        c = c + 32'd1;

        // addi: 4 cycles.
        add(1'b0, 6'b001000, 6'b000000, 1'b0, O_FETCH, c);
        add(1'b0, 6'b001000, 6'b000000, 1'b0, O_DECODE, c);
        add(1'b0, 6'b001000, 6'b000000, 1'b1, O_ADDIEX, c);
        add(1'b0, 6'b001000, 6'b000000, 1'b0, O_ADDIWB, c);
        c = c + 32'd1;

        // j: 3 cycles.
        add(1'b0, 6'b000010, 6'b000000, 1'b0, O_FETCH, c);
        add(1'b0, 6'b000010, 6'b000000, 1'b0, O_DECODE, c);
        add(1'b0, 6'b000010, 6'b000000, 1'b0, O_JUMP, c);
        c = c + 32'd1;

        // Illegal opcodes: 2 cycles, no count.
        add(1'b0, 6'b111111, 6'b000000, 1'b0, O_FETCH, c);
        add(1'b0, 6'b111111, 6'b000000, 1'b1, O_DECODE_ILL, c);
        add(1'b0, 6'b000101, 6'b000000, 1'b0, O_FETCH, c);
        add(1'b0, 6'b000101, 6'b000000, 1'b0, O_DECODE_ILL, c);

        // Unknown funct and the optional multiply.
        add_rbad(6'b000000);
`ifdef ALU_MUL_EN
        add_r(6'b011000, 3'b101);
`else
        add_rbad(6'b011000);
`endif

        // A completing instruction after the illegal ones: count resumes.
        add_r(6'b100000, 3'b010);
        add(1'b0, 6'b101011, 6'b000000, 1'b0, O_FETCH, c);

        foreach (vq[i]) begin
            @(negedge clk);
            rst           = vq[i].rst;
            bus.Opcode    = vq[i].op;
            bus.Funct     = vq[i].fn;
            bus.Zero_Flag = vq[i].zf;
            #1;
            chk_outs("vec", i, vq[i].exp);
            chk_cnt("vec", i, vq[i].cnt);
            chk_strobes("vec", i);
        end

        // sw continuing from the last FETCH vector: DECODE, MEMADR, MEMWR.
        bus.Zero_Flag = 1'b0;
        @(negedge clk); #1; chk_outs("rst_sw_decode", 0, O_DECODE);
        @(negedge clk); #1; chk_outs("rst_sw_memadr", 0, O_MEMADR);
        @(negedge clk); #1; chk_outs("rst_sw_memwr", 0, O_MEMWR);
        // Reset mid-MEMWR: strobe must drop in the same cycle.
        #2 rst = 1'b1;
        #1;
        chk_outs("rst_mid_memwr", 0, O_IDLE);
        chk_cnt("rst_mid_memwr", 0, 32'd0);
        @(negedge clk); #1;
        chk_outs("rst_held", 0, O_IDLE);
        rst = 1'b0;
        #1;
        chk_outs("rst_release", 0, O_IDLE);
        bus.Opcode = 6'b000100;
        @(negedge clk); #1;
        chk_outs("rst_fetch", 0, O_FETCH);
        chk_cnt("rst_fetch", 0, 32'd0);
        @(negedge clk); #1;
        chk_outs("beq_decode", 0, O_DECODE);
        // Zero_Flag reaches PC_En within the BRANCH cycle.
        @(negedge clk); #1;
        chk_outs("beq_zf0", 0, o_branch(1'b0));
        bus.Zero_Flag = 1'b1;
        #1;
        chk_outs("beq_zf1", 0, o_branch(1'b1));
        @(negedge clk);
        bus.Zero_Flag = 1'b0;
        #1;
        chk_outs("beq_next_fetch", 0, O_FETCH);
        chk_cnt("beq_next_fetch", 0, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
